// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode plus ID/EX pipeline register.
// Latency: 1 cycle from an accepted IF/ID instruction to the ex_* outputs.
// Backpressure: hazard_stall holds PC and IF/ID while a bubble enters EX.
// Optional build macro BRANCH_IN_ID_EN resolves beq/bne in ID instead of EX.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_pc4,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_addr_1,
  output logic [REG_AW-1:0] rf_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic              hazard_stall,
  output logic              jump_taken,
  output logic [DATA_W-1:0] jump_target,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic [3:0]        ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest
);

  // Instruction fields
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic              w_unused;

  assign w_op       = if_id_instr[31:26];
  assign w_funct    = if_id_instr[5:0];
  assign w_rs       = if_id_instr[25:21];
  assign w_rt       = if_id_instr[20:16];
  assign w_rd       = if_id_instr[15:11];
  assign w_imm_sext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
  assign w_imm_zext = {{(DATA_W-16){1'b0}}, if_id_instr[15:0]};
  // shamt is not used by any supported instruction
  assign w_unused   = ^if_id_instr[10:6];

  assign rf_addr_1 = w_rs;
  assign rf_addr_2 = w_rt;

  // Decoded control word
  logic       w_dec_ok;
  logic       w_rtype;
  logic       w_is_j;
  logic       w_is_sw;
  logic       w_is_br;
  logic       w_zext;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_alu_src;
  logic       w_bne;
  logic [3:0] w_alu_ctrl;

  // Opcode/funct decode; anything unrecognised leaves w_dec_ok low (bubble)
  always_comb begin
    w_dec_ok     = 1'b0;
    w_rtype      = 1'b0;
    w_is_j       = 1'b0;
    w_is_sw      = 1'b0;
    w_is_br      = 1'b0;
    w_zext       = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_bne        = 1'b0;
    w_alu_ctrl   = 4'd0;
    case (w_op)
      6'h00: begin
        w_rtype     = 1'b1;
        w_reg_write = 1'b1;
        w_dec_ok    = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_alu_ctrl = 4'd2;
          6'h22, 6'h23: w_alu_ctrl = 4'd6;
          6'h24:        w_alu_ctrl = 4'd0;
          6'h25:        w_alu_ctrl = 4'd1;
          6'h27:        w_alu_ctrl = 4'd12;
          6'h2A:        w_alu_ctrl = 4'd7;
          default: begin
            w_dec_ok    = 1'b0;
            w_reg_write = 1'b0;
          end
        endcase
      end
      6'h23: begin
        w_dec_ok = 1'b1; w_alu_ctrl = 4'd2; w_alu_src = 1'b1;
        w_mem_read = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1;
      end
      6'h2B: begin
        w_dec_ok = 1'b1; w_is_sw = 1'b1; w_alu_ctrl = 4'd2;
        w_alu_src = 1'b1; w_mem_write = 1'b1;
      end
      6'h08: begin
        w_dec_ok = 1'b1; w_alu_ctrl = 4'd2; w_alu_src = 1'b1; w_reg_write = 1'b1;
      end
      6'h0A: begin
        w_dec_ok = 1'b1; w_alu_ctrl = 4'd7; w_alu_src = 1'b1; w_reg_write = 1'b1;
      end
      6'h0C: begin
        w_dec_ok = 1'b1; w_alu_ctrl = 4'd0; w_alu_src = 1'b1;
        w_reg_write = 1'b1; w_zext = 1'b1;
      end
      6'h0D: begin
        w_dec_ok = 1'b1; w_alu_ctrl = 4'd1; w_alu_src = 1'b1;
        w_reg_write = 1'b1; w_zext = 1'b1;
      end
      6'h04: begin
        w_dec_ok = 1'b1; w_is_br = 1'b1; w_alu_ctrl = 4'd6;
      end
      6'h05: begin
        w_dec_ok = 1'b1; w_is_br = 1'b1; w_bne = 1'b1; w_alu_ctrl = 4'd6;
      end
      6'h02: w_is_j = 1'b1;
      default: w_dec_ok = 1'b0;
    endcase
  end

  logic [REG_AW-1:0] w_dest;
  logic              w_reg_write_eff;
  logic              w_uses_rs;
  logic              w_uses_rt;

  assign w_dest          = w_rtype ? w_rd : w_rt;
  assign w_reg_write_eff = w_reg_write & (w_dest != '0);
  assign w_uses_rs       = w_dec_ok;
  assign w_uses_rt       = w_dec_ok & (w_rtype | w_is_sw | w_is_br);

  // Registered ID/EX state
  logic              r_ex_valid;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic              r_ex_mem_to_reg;
  logic              r_ex_alu_src;
  logic              r_ex_branch;
  logic              r_ex_bne;
  logic [3:0]        r_ex_alu_ctrl;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [DATA_W-1:0] r_ex_pc4;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_dest;

  // Load-use hazard against a load currently in EX
  logic w_lu_stall;
  assign w_lu_stall = if_id_valid & r_ex_valid & r_ex_mem_read & (r_ex_dest != '0) &
                      (((r_ex_dest == w_rs) & w_uses_rs) | ((r_ex_dest == w_rt) & w_uses_rt));

  logic w_br_id;
  logic w_br_stall;

`ifdef BRANCH_IN_ID_EN
  // Branch compares in ID, so any result still in EX must land first
  logic w_eq;
  assign w_eq         = (rf_data_1 == rf_data_2);
  assign w_br_id      = w_is_br;
  assign w_br_stall   = if_id_valid & w_is_br & r_ex_valid & r_ex_reg_write &
                        (r_ex_dest != '0) & ((r_ex_dest == w_rs) | (r_ex_dest == w_rt));
  assign branch_taken = if_id_valid & ~flush & ~hazard_stall & w_is_br & (w_eq ^ w_bne);
`else
  assign w_br_id      = 1'b0;
  assign w_br_stall   = 1'b0;
  assign branch_taken = 1'b0;
`endif

  assign hazard_stall  = w_lu_stall | w_br_stall;
  assign jump_taken    = if_id_valid & ~flush & ~hazard_stall & w_is_j;
  assign jump_target   = {if_id_pc4[DATA_W-1:DATA_W-4], if_id_instr[25:0], 2'b00};
  assign branch_target = if_id_pc4 + {w_imm_sext[DATA_W-3:0], 2'b00};

  // Jumps and ID-resolved branches never enter EX; they leave a bubble behind
  logic w_load;
  assign w_load = if_id_valid & w_dec_ok & ~w_br_id;

  // ID/EX register: reset, flush, stall and empty/undecodable slots all load a bubble
  always_ff @(posedge clk) begin
    if (reset || flush || hazard_stall || !w_load) begin
      r_ex_valid      <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_bne        <= 1'b0;
      r_ex_alu_ctrl   <= 4'd0;
      r_ex_rs_data    <= '0;
      r_ex_rt_data    <= '0;
      r_ex_imm        <= '0;
      r_ex_pc4        <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_dest       <= '0;
    end else begin
      r_ex_valid      <= 1'b1;
      r_ex_reg_write  <= w_reg_write_eff;
      r_ex_mem_read   <= w_mem_read;
      r_ex_mem_write  <= w_mem_write;
      r_ex_mem_to_reg <= w_mem_to_reg;
      r_ex_alu_src    <= w_alu_src;
      r_ex_branch     <= w_is_br;
      r_ex_bne        <= w_bne;
      r_ex_alu_ctrl   <= w_alu_ctrl;
      r_ex_rs_data    <= rf_data_1;
      r_ex_rt_data    <= rf_data_2;
      r_ex_imm        <= w_zext ? w_imm_zext : w_imm_sext;
      r_ex_pc4        <= if_id_pc4;
      r_ex_rs         <= w_rs;
      r_ex_rt         <= w_rt;
      r_ex_dest       <= w_dest;
    end
  end

  assign ex_valid      = r_ex_valid;
  assign ex_reg_write  = r_ex_reg_write;
  assign ex_mem_read   = r_ex_mem_read;
  assign ex_mem_write  = r_ex_mem_write;
  assign ex_mem_to_reg = r_ex_mem_to_reg;
  assign ex_alu_src    = r_ex_alu_src;
  assign ex_branch     = r_ex_branch;
  assign ex_bne        = r_ex_bne;
  assign ex_alu_ctrl   = r_ex_alu_ctrl;
  assign ex_rs_data    = r_ex_rs_data;
  assign ex_rt_data    = r_ex_rt_data;
  assign ex_imm        = r_ex_imm;
  assign ex_pc4        = r_ex_pc4;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_dest       = r_ex_dest;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ID/EX words are queued when an
// instruction is presented and popped after the clock edge that registers it.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        flush;
  logic [4:0]  rf_addr_1, rf_addr_2;
  logic [31:0] rf_data_1, rf_data_2;
  logic        hazard_stall, jump_taken, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_branch, ex_bne;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_dest;

  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, bne;
    logic [3:0]  alu_ctrl;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  rs, rt, dest;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs;
  int   total = 0;
  int   passed = 0;

  assign obs = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_alu_src, ex_branch, ex_bne, ex_alu_ctrl, ex_rs_data, ex_rt_data,
                ex_imm, ex_pc4, ex_rs, ex_rt, ex_dest};

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .flush(flush), .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .hazard_stall(hazard_stall),
    .jump_taken(jump_taken), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_bne(ex_bne),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest)
  );

  function automatic exp_t e(input logic v, rw, mr, mw, m2r, as, br, bn,
                             input logic [3:0] alu, input logic [31:0] rsd, rtd, imm, pc4,
                             input logic [4:0] rs, rt, dest);
    e = {v, rw, mr, mw, m2r, as, br, bn, alu, rsd, rtd, imm, pc4, rs, rt, dest};
  endfunction

  function automatic exp_t bubble();
    bubble = '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, x);
  endtask

  task automatic present(input logic v, input logic [31:0] instr, pc4,
                         input logic fl, input logic [31:0] d1, d2);
    if_id_valid = v; if_id_instr = instr; if_id_pc4 = pc4;
    flush = fl; rf_data_1 = d1; rf_data_2 = d2;
    #1;
  endtask

  // Advance one edge and compare the registered stage against the oldest expectation
  task automatic step(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      x = exp_q.pop_front();
      assert (obs === x) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, x);
    end
  endtask

  initial begin
    reset = 1'b1;
    present(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(bubble());
    step("reset_bubble");
    reset = 1'b0;
    chk("reset_stall", {31'd0, hazard_stall}, 32'd0);

    // add $16,$17,$18
    present(1'b1, 32'h02328020, 32'h10, 1'b0, 32'd4, 32'd3);
    chk("add_rf_addr_1", {27'd0, rf_addr_1}, 32'd17);
    chk("add_rf_addr_2", {27'd0, rf_addr_2}, 32'd18);
    exp_q.push_back(e(1,1,0,0,0,0,0,0, 4'd2, 32'd4, 32'd3, 32'hFFFF8020, 32'h10, 5'd17, 5'd18, 5'd16));
    step("add");

    // lw $8,0($17) followed by a dependent add
    present(1'b1, 32'h8E280000, 32'h14, 1'b0, 32'h1000, 32'd7);
    chk("lw_no_stall", {31'd0, hazard_stall}, 32'd0);
    exp_q.push_back(e(1,1,1,0,1,1,0,0, 4'd2, 32'h1000, 32'd7, 32'h0, 32'h14, 5'd17, 5'd8, 5'd8));
    step("lw");
    present(1'b1, 32'h01124820, 32'h18, 1'b0, 32'd5, 32'd6);
    chk("loaduse_stall", {31'd0, hazard_stall}, 32'd1);
    exp_q.push_back(bubble());
    step("loaduse_bubble");
    chk("loaduse_release", {31'd0, hazard_stall}, 32'd0);
    exp_q.push_back(e(1,1,0,0,0,0,0,0, 4'd2, 32'd5, 32'd6, 32'h4820, 32'h18, 5'd8, 5'd18, 5'd9));
    step("add_after_stall");

    // addi sign-extends, ori zero-extends
    present(1'b1, 32'h226AFFFF, 32'h1C, 1'b0, 32'd9, 32'd0);
    exp_q.push_back(e(1,1,0,0,0,1,0,0, 4'd2, 32'd9, 32'd0, 32'hFFFFFFFF, 32'h1C, 5'd19, 5'd10, 5'd10));
    step("addi");
    present(1'b1, 32'h366AFFFF, 32'h20, 1'b0, 32'd9, 32'd0);
    exp_q.push_back(e(1,1,0,0,0,1,0,0, 4'd1, 32'd9, 32'd0, 32'h0000FFFF, 32'h20, 5'd19, 5'd10, 5'd10));
    step("ori");

    // sw $8,4($17)
    present(1'b1, 32'hAE280004, 32'h24, 1'b0, 32'h2000, 32'h55);
    exp_q.push_back(e(1,0,0,1,0,1,0,0, 4'd2, 32'h2000, 32'h55, 32'h4, 32'h24, 5'd17, 5'd8, 5'd8));
    step("sw");

    // j resolves in ID; flushed j does not
    present(1'b1, 32'h08000040, 32'h104, 1'b0, 32'd0, 32'd0);
    chk("j_taken", {31'd0, jump_taken}, 32'd1);
    chk("j_target", jump_target, 32'h100);
    exp_q.push_back(bubble());
    step("j_bubble");
    present(1'b1, 32'h08000040, 32'h104, 1'b1, 32'd0, 32'd0);
    chk("j_flushed", {31'd0, jump_taken}, 32'd0);
    exp_q.push_back(bubble());
    step("j_flush_bubble");

    // beq $17,$21 with equal operands
    present(1'b1, 32'h12350002, 32'h100, 1'b0, 32'd4, 32'd4);
    chk("beq_target", branch_target, 32'h108);
`ifdef BRANCH_IN_ID_EN
    chk("beq_taken_id", {31'd0, branch_taken}, 32'd1);
    exp_q.push_back(bubble());
`else
    chk("beq_taken_off", {31'd0, branch_taken}, 32'd0);
    exp_q.push_back(e(1,0,0,0,0,0,1,0, 4'd6, 32'd4, 32'd4, 32'h2, 32'h100, 5'd17, 5'd21, 5'd21));
`endif
    step("beq");

    // write to r0 is suppressed
    present(1'b1, 32'h02320020, 32'h200, 1'b0, 32'd1, 32'd2);
    exp_q.push_back(e(1,0,0,0,0,0,0,0, 4'd2, 32'd1, 32'd2, 32'h20, 32'h200, 5'd17, 5'd18, 5'd0));
    step("add_r0");

    // undecodable opcode and empty slot both bubble
    present(1'b1, 32'hFC000000, 32'h204, 1'b0, 32'd1, 32'd2);
    exp_q.push_back(bubble());
    step("illegal_op");
    present(1'b0, 32'h02328020, 32'h208, 1'b0, 32'd4, 32'd3);
    exp_q.push_back(bubble());
    step("not_valid");

    // reset asserted while a load-use stall is pending
    present(1'b1, 32'h8E280000, 32'h300, 1'b0, 32'h40, 32'd0);
    exp_q.push_back(e(1,1,1,0,1,1,0,0, 4'd2, 32'h40, 32'd0, 32'h0, 32'h300, 5'd17, 5'd8, 5'd8));
    step("lw2");
    present(1'b1, 32'h01124820, 32'h304, 1'b0, 32'd7, 32'd8);
    chk("stall_before_reset", {31'd0, hazard_stall}, 32'd1);
    reset = 1'b1;
    exp_q.push_back(bubble());
    step("reset_in_stall");
    reset = 1'b0;
    #1;
    chk("stall_after_reset", {31'd0, hazard_stall}, 32'd0);
    exp_q.push_back(e(1,1,0,0,0,0,0,0, 4'd2, 32'd7, 32'd8, 32'h4820, 32'h304, 5'd8, 5'd18, 5'd9));
    step("add_after_reset");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register.
- Decodes the IF/ID instruction and drives the register file read addresses combinationally.
- Registers the read operands, immediate and control word for EX.
- Detects load-use hazards (stall plus bubble), honours flush, and resolves jumps in ID.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_instr  in  32  instruction word.
- if_id_pc4  in  DATA_W  PC+4 of that instruction.
- flush  in  1  kill the instruction in ID (from EX branch/redirect).
- rf_addr_1  out  REG_AW  register file read address 1 = instr[25:21]; combinational.
- rf_addr_2  out  REG_AW  register file read address 2 = instr[20:16]; combinational.
- rf_data_1  in  DATA_W  register file read data 1.
- rf_data_2  in  DATA_W  register file read data 2.
- hazard_stall  out  1  hold PC and IF/ID; combinational.
- jump_taken  out  1  j decoded in ID; combinational.
- jump_target  out  DATA_W  {if_id_pc4[31:28], instr[25:0], 2'b00}.
- branch_taken  out  1  ID branch resolved taken (see Optional Feature).
- branch_target  out  DATA_W  if_id_pc4 + (sext(imm) << 2).
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_bne  out  1 each  registered control.
- ex_alu_ctrl  out  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered operands.
- ex_rs, ex_rt, ex_dest  out  REG_AW  registered fields; ex_dest = rd (R-type) else rt.

Behaviour:
- Latency: 1 cycle. Instruction accepted at edge N is visible on ex_* after edge N.
- Decode table:
  - R-type (op 0x00), funct 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
  - lw 0x23: ADD, alu_src, mem_read, mem_to_reg, reg_write.
  - sw 0x2B: ADD, alu_src, mem_write.
  - addi 0x08: ADD, sign-ext. slti 0x0A: SLT, sign-ext.
  - andi 0x0C / ori 0x0D: AND/OR, zero-ext.
  - beq 0x04 / bne 0x05: SUB, ex_branch; ex_bne=1 for bne.
  - j 0x02: jump_taken=1, bubble into EX.
  - Any other opcode/funct: bubble, ex_valid=0.
- Register write to r0 suppressed: ex_reg_write=0 whenever dest==0.
- uses_rs: all decoded ops except j. uses_rt: R-type, sw, beq, bne.
- hazard_stall = if_id_valid & ex_valid & ex_mem_read & ex_dest!=0 & ((ex_dest==rs & uses_rs) | (ex_dest==rt & uses_rt)).
- jump_taken is gated by if_id_valid & !flush & !hazard_stall.
- Register update priority per edge: reset > flush > hazard_stall > !if_id_valid > normal load.
  - The first four cases load a bubble: every ex_* output = 0.
- Reset: all ex_* outputs 0. Combinational outputs reflect inputs; with a registered bubble, hazard_stall=0.
- Reset mid-stall: bubble loaded, stall drops the next cycle.
- Simultaneous flush and stall: flush wins; bubble loaded; hazard_stall still asserted combinationally (harmless, IF redirects).
- The register file writes on the opposite clock edge, so rf_data is current at posedge. No WB bypass is needed.

Optional Feature:
- Macro BRANCH_IN_ID_EN.
- Defined:
  - beq/bne compare rf_data_1 vs rf_data_2 in ID.
  - branch_taken = valid & !flush & !hazard_stall & (eq ^ bne).
  - beq/bne load a bubble into EX (ex_branch=0).
  - Extra stall when ex_valid & ex_reg_write & ex_dest!=0 & ex_dest matches rs or rt of the branch.
- Undefined:
  - branch_taken=0, branch_target still driven.
  - Branches pass to EX with ex_branch/ex_bne set.

Test Plan:
- Reset then 0x02328020 (add $16,$17,$18), rf_data 4/3 -> next cycle: ex_valid=1, ex_alu_ctrl=2, ex_rs_data=4, ex_rt_data=3, ex_dest=16, ex_reg_write=1.
- 0x8E280000 (lw $8,0($17)) then 0x01124820 (add $9,$8,$18):
  - 2nd cycle: hazard_stall=1, registered bubble.
  - 3rd cycle: stall=0, add loaded with ex_rs=8.
- 0x226AFFFF (addi $10,$19,-1) -> ex_imm=0xFFFFFFFF, alu_src=1. 0x366AFFFF (ori) -> ex_imm=0x0000FFFF, alu_ctrl=1.
- 0x08000040 (j) with pc4=0x00000104 -> jump_taken=1, jump_target=0x00000100, EX bubble. Same with flush=1 -> jump_taken=0, bubble.
- 0x12350002 (beq $17,$21), data 4/4, pc4=0x100:
  - Macro on: branch_taken=1, target=0x108.
  - Macro off: ex_branch=1, ex_alu_ctrl=6.
- Writing dest 0 (add $0,$17,$18 = 0x02320020) -> ex_reg_write=0. Assert reset during a stall -> all ex_* outputs 0 next cycle.
